exec_div_iter: RTL and testbench
================================

EXEC_DIV_ITER -- requirements
Module: exec_div_iter

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 32 and 64.
REQ-002 Parameter WORD_OPS, default 1, enables 32-bit word-mode ops; legal only when XLEN==64.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a_in  input  XLEN  dividend.
REQ-008 b_in  input  XLEN  divisor.
REQ-009 is_signed  input  1  signed (DIV/REM) vs unsigned (DIVU/REMU).
REQ-010 do_rem  input  1  return remainder instead of quotient.
REQ-011 is_word  input  1  word mode (DIVW family); ignored, treated as 0, when WORD_OPS==0.
REQ-012 flush  input  1  abort any in-flight or pending operation.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 result  output  XLEN  quotient or remainder.

Function
REQ-016 Request accepted when in_valid && in_ready && !flush; a_in, b_in, is_signed, do_rem, is_word captured internally; inputs need not be held afterwards.
REQ-017 in_ready SHALL be 1 only in state IDLE.
REQ-018 States: IDLE, PREP, ITER, FIXUP, DONE.
REQ-019 IDLE -> PREP on acceptance; otherwise stay.
REQ-020 PREP (1 cycle): operating width N = 32 if word mode else XLEN; take low N bits of operands; if signed, form magnitudes and record quotient sign (sign(a) xor sign(b)) and remainder sign (sign(a)); detect special cases.
REQ-021 PREP -> DONE if b==0 or signed overflow (a==most-negative N-bit, b==-1); else PREP -> ITER.
REQ-022 ITER: restoring radix-2, one quotient bit per cycle, MSB first, exactly N cycles, iteration counter 0..N-1; ITER -> FIXUP after count N-1.
REQ-023 FIXUP (1 cycle): negate quotient/remainder per recorded signs; select per do_rem; word mode sign-extends bit 31 of the 32-bit result to XLEN for both signed and unsigned ops.
REQ-024 FIXUP -> DONE; out_valid SHALL be 1 exactly in DONE.
REQ-025 Normal latency: out_valid first high N+3 cycles after the accepting cycle (67 for 64-bit, 35 for word/32-bit); special-case latency 2 cycles.
REQ-026 Divide-by-zero: quotient = all ones (N bits), remainder = a (N bits), then word-mode extension.
REQ-027 Signed overflow: quotient = a (most-negative), remainder = 0, then word-mode extension.
REQ-028 DONE -> IDLE when out_ready; result and out_valid held stable while out_valid && !out_ready.
REQ-029 No new request accepted in the same cycle as DONE->IDLE (in_ready low in DONE).
REQ-030 flush in any state: next state IDLE, out_valid low next cycle, result discarded; flush in IDLE with in_valid SHALL NOT accept.
REQ-031 flush has priority over out_ready and over iteration progress in the same cycle.
REQ-032 result SHALL equal 0 whenever out_valid is 0.

Reset
REQ-033 rst_n low asynchronously forces state IDLE, out_valid 0, result 0, iteration counter 0; in_ready 1 once rst_n high.
REQ-034 Reset mid-operation discards the operation; no out_valid pulse follows release.
REQ-035 First acceptance possible on the first rising edge with rst_n high.

Verification
REQ-036 XLEN=64, unsigned, a=100, b=7, do_rem=0, out_ready=1 -> result 14, out_valid at cycle 67 after accept, one cycle wide.
REQ-037 Signed, a=-7, b=2: do_rem=0 -> 0xFFFF_FFFF_FFFF_FFFD (-3); do_rem=1 -> 0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-038 b=0, a=0x1234, do_rem=0 -> all ones at cycle 2; do_rem=1 -> 0x1234 at cycle 2.
REQ-039 Signed, is_word=1, a=0x8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 (quotient), 0 (remainder), cycle 2; unsigned word a=0xFFFF_FFFE, b=1 -> 0xFFFF_FFFF_FFFF_FFFE at cycle 35.
REQ-040 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-041 flush at ITER count 10, and rst_n pulse mid-ITER -> IDLE next cycle/immediately, no out_valid; following request a=9, b=3 -> 3.

Source files
------------

// File: rtl/exec_div_iter_if.sv
// Request/response bundle for the iterative divider.
//   master: requester side (drives operands, flush, out_ready)
//   slave : divider side (drives in_ready, out_valid, result)
interface exec_div_iter_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            is_signed;
  logic            do_rem;
  logic            is_word;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, a_in, b_in, is_signed, do_rem, is_word, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a_in, b_in, is_signed, do_rem, is_word, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/exec_div_iter.sv
// Iterative restoring radix-2 integer divider (DIV/DIVU/REM/REMU, plus the
// 32-bit word forms when XLEN==64 and WORD_OPS!=0).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : exec_div_iter_if.slave -- valid/ready request with operands
//                and op controls, flush, valid/ready result channel.
// Flow: IDLE -> PREP -> ITER (N cycles) -> FIXUP -> DONE, or PREP -> DONE for
// divide-by-zero and signed overflow. result reads 0 outside DONE.
module exec_div_iter #(
  parameter int XLEN     = 64,
  parameter int WORD_OPS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  exec_div_iter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

  localparam int              CNT_W   = $clog2(XLEN);
  localparam bit              WORD_EN = (WORD_OPS != 0) && (XLEN == 64);
  localparam logic [XLEN-1:0] LOW32   = XLEN'(64'h0000_0000_FFFF_FFFF);
  localparam logic [XLEN-1:0] MIN32   = XLEN'(64'h0000_0000_8000_0000);
  localparam logic [XLEN-1:0] MINX    = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q;        // captured dividend, then dividend shift register
  logic [XLEN-1:0]   b_q;        // captured divisor, then divisor magnitude
  logic              signed_q, rem_sel_q, word_q;
  logic              q_neg_q, r_neg_q;
  logic [XLEN-1:0]   rem_q, quo_q, res_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic [XLEN-1:0]   mask, a_low, b_low, a_mag, b_mag, special_val;
  logic              a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN:0]     trial, diff;
  logic              q_bit, last_iter;
  logic [XLEN-1:0]   q_fix, q_sgn, r_sgn, fix_val;

  // Word results keep the low 32 bits and copy bit 31 upward.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v,
                                          input logic word,
                                          input logic [XLEN-1:0] m);
    return (v & m) | ((word && v[31]) ? ~m : '0);
  endfunction

  assign accept = bus.in_valid && (state_q == IDLE) && !bus.flush;

  // Operand preparation (meaningful while in PREP, when a_q/b_q are raw).
  assign mask     = word_q ? LOW32 : '1;
  assign a_low    = a_q & mask;
  assign b_low    = b_q & mask;
  assign a_neg    = signed_q && (word_q ? a_q[31] : a_q[XLEN-1]);
  assign b_neg    = signed_q && (word_q ? b_q[31] : b_q[XLEN-1]);
  assign a_mag    = a_neg ? ((-a_low) & mask) : a_low;
  assign b_mag    = b_neg ? ((-b_low) & mask) : b_low;
  assign div_zero = (b_low == '0);
  assign overflow = signed_q && (a_low == (word_q ? MIN32 : MINX)) && (b_low == mask);
  assign special  = div_zero || overflow;
  assign special_val = div_zero ? (rem_sel_q ? a_low : mask)
                                : (rem_sel_q ? '0    : a_low);

  // One restoring step: the partial remainder needs one extra bit because
  // it can reach twice the divisor before the trial subtraction.
  assign trial     = {rem_q, a_q[XLEN-1]};
  assign diff      = trial - {1'b0, b_q};
  assign q_bit     = ~diff[XLEN];
  assign last_iter = (cnt_q == (word_q ? CNT_W'(31) : CNT_W'(XLEN-1)));

  assign q_fix   = quo_q & mask;
  assign q_sgn   = q_neg_q ? ((-q_fix) & mask) : q_fix;
  assign r_sgn   = r_neg_q ? ((-rem_q) & mask) : rem_q;
  assign fix_val = rem_sel_q ? r_sgn : q_sgn;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = PREP;
      PREP:    state_d = special ? DONE : ITER;
      ITER:    if (last_iter) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush overrides every other transition, including acceptance.
    if (bus.flush) state_d = IDLE;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = (state_q == DONE) ? res_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          a_q       <= bus.a_in;
          b_q       <= bus.b_in;
          signed_q  <= bus.is_signed;
          rem_sel_q <= bus.do_rem;
          word_q    <= bus.is_word && WORD_EN;
        end
        PREP: begin
          // Left-align a word dividend so its MSB enters the divider first.
          a_q     <= word_q ? (a_mag << (XLEN - 32)) : a_mag;
          b_q     <= b_mag;
          q_neg_q <= a_neg ^ b_neg;
          r_neg_q <= a_neg;
          rem_q   <= '0;
          quo_q   <= '0;
          cnt_q   <= '0;
          res_q   <= ext(special_val, word_q, mask);
        end
        ITER: begin
          rem_q <= q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], q_bit};
          a_q   <= {a_q[XLEN-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        FIXUP: res_q <= ext(fix_val, word_q, mask);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_div_iter.sv
module tb_exec_div_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exec_div_iter_if #(.XLEN(64)) bus ();

  exec_div_iter #(.XLEN(64), .WORD_OPS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Drive a request at the negedge; return #1 after the accepting edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sgn, input logic rem, input logic word,
                          input logic ordy);
    @(negedge clk);
    bus.a_in = a; bus.b_in = b;
    bus.is_signed = sgn; bus.do_rem = rem; bus.is_word = word;
    bus.out_ready = ordy; bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL start_in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    // Scramble the inputs: the divider must work from its captured copy.
    bus.in_valid = 1'b0;
    bus.a_in = 64'hA5A5_5A5A_F0F0_0F0F; bus.b_in = 64'h0;
    bus.is_signed = ~sgn; bus.do_rem = ~rem; bus.is_word = ~word;
  endtask

  // Cycles after the accepting cycle until out_valid; 200 means timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic sgn, input logic rem, input logic word,
                        output logic [63:0] res, output int lat, output logic after);
    start_op(a, b, sgn, rem, word, 1'b1);
    wait_valid(lat);
    res = bus.result;
    @(posedge clk); #1;
    after = bus.out_valid;
  endtask

  task automatic test_reset;
    int lat;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 64'h0) begin
      errors++; $display("FAIL reset_outputs got valid=%b result=%h want 0/0", bus.out_valid, bus.result);
    end
    // Release and present a request in the same cycle: first edge must accept.
    @(negedge clk);
    rst_n = 1'b1;
    bus.a_in = 64'd9; bus.b_in = 64'd3; bus.is_signed = 1'b0; bus.do_rem = 1'b0;
    bus.is_word = 1'b0; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL first_edge_accept in_ready got %b want 0", bus.in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 67 || bus.result !== 64'd3) begin
      errors++; $display("FAIL first_op got lat=%0d result=%h want 67/3", lat, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    logic [63:0] res; int lat; logic after;
    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", res, 64'd14); end
    checks++;
    if (lat !== 67) begin errors++; $display("FAIL divu_latency got %0d want 67", lat); end
    checks++;
    if (after !== 1'b0) begin errors++; $display("FAIL divu_one_cycle out_valid got %b want 0", after); end
    run_op(64'd100, 64'd7, 1'b0, 1'b1, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", res, 64'd2); end
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'h0FFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL divu_max_16 got %h want %h", res, 64'h0FFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_signed;
    logic [63:0] res; int lat; logic after;
    run_op(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h want %h", res, 64'hFFFF_FFFF_FFFF_FFFD); end
    run_op(-64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want %h", res, 64'hFFFF_FFFF_FFFF_FFFF); end
    run_op(-64'sd100, -64'sd7, 1'b1, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'd14) begin errors++; $display("FAIL div_m100_m7 got %h want %h", res, 64'd14); end
    run_op(-64'sd100, -64'sd7, 1'b1, 1'b1, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_m100_m7 got %h want %h", res, 64'hFFFF_FFFF_FFFF_FFFE); end
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'h8000_0000_0000_0000 || lat !== 2) begin
      errors++; $display("FAIL div_overflow64 got %h lat=%0d want 8000000000000000 lat=2", res, lat);
    end
  endtask

  task automatic test_div_zero;
    logic [63:0] res; int lat; logic after;
    run_op(64'h1234, 64'h0, 1'b0, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 2) begin
      errors++; $display("FAIL divz_quot got %h lat=%0d want ffffffffffffffff lat=2", res, lat);
    end
    checks++;
    if (after !== 1'b0) begin errors++; $display("FAIL divz_one_cycle out_valid got %b want 0", after); end
    run_op(64'h1234, 64'h0, 1'b1, 1'b1, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'h1234 || lat !== 2) begin
      errors++; $display("FAIL divz_rem got %h lat=%0d want 1234 lat=2", res, lat);
    end
  endtask

  task automatic test_word;
    logic [63:0] res; int lat; logic after;
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1, res, lat, after);
    checks++;
    if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== 2) begin
      errors++; $display("FAIL divw_overflow got %h lat=%0d want ffffffff80000000 lat=2", res, lat);
    end
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b1, res, lat, after);
    checks++;
    if (res !== 64'h0 || lat !== 2) begin
      errors++; $display("FAIL remw_overflow got %h lat=%0d want 0 lat=2", res, lat);
    end
    run_op(64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b0, 1'b1, res, lat, after);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 35) begin
      errors++; $display("FAIL divuw_ext got %h lat=%0d want fffffffffffffffe lat=35", res, lat);
    end
    // Upper operand bits must be ignored in word mode.
    run_op(64'hDEAD_BEEF_0000_0064, 64'h1234_0000_0000_0007, 1'b0, 1'b1, 1'b1, res, lat, after);
    checks++;
    if (res !== 64'd2) begin errors++; $display("FAIL remuw_upper_ignored got %h want 2", res); end
    run_op(64'h0000_0000_8000_0000, 64'h0, 1'b0, 1'b1, 1'b1, res, lat, after);
    checks++;
    if (res !== 64'hFFFF_FFFF_8000_0000) begin
      errors++; $display("FAIL remuw_divz_ext got %h want ffffffff80000000", res);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [63:0] held; int bad;
    start_op(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    held = bus.result;
    checks++;
    if (held !== 64'd100) begin errors++; $display("FAIL bp_result got %h want %h", held, 64'd100); end
    // A new request offered during DONE must not be taken.
    bus.a_in = 64'd50; bus.b_in = 64'd5; bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.result !== 64'd100 || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush;
    int lat; int seen; logic [63:0] res; logic after;
    // Flush while idle with a valid request: nothing accepted.
    @(negedge clk);
    bus.a_in = 64'd9; bus.b_in = 64'd3; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_accepted in_ready got %b want 1", bus.in_ready); end
    // Flush at iteration count 10 (cycle 12 after accept).
    start_op(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_iter got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_iter_ghost got %0d valid cycles want 0", seen); end
    // Flush in DONE beats out_ready=0 hold.
    start_op(64'd40, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 64'h0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done got valid=%b result=%h ready=%b want 0/0/1", bus.out_valid, bus.result, bus.in_ready);
    end
    run_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'd3 || lat !== 67) begin errors++; $display("FAIL flush_next_op got %h lat=%0d want 3 lat=67", res, lat); end
  endtask

  task automatic test_reset_mid;
    int lat; int seen; logic [63:0] res; logic after;
    start_op(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_ghost got %0d valid cycles want 0", seen); end
    run_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'd3) begin errors++; $display("FAIL reset_next_op got %h want 3", res); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] res; int lat; logic after;
    run_op(64'd81, 64'd9, 1'b0, 1'b0, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'd9) begin errors++; $display("FAIL b2b_first got %h want 9", res); end
    checks++;
    if (bus.result !== 64'h0) begin errors++; $display("FAIL b2b_idle_result got %h want 0", bus.result); end
    run_op(64'd81, 64'd10, 1'b0, 1'b1, 1'b0, res, lat, after);
    checks++;
    if (res !== 64'd1 || lat !== 67) begin errors++; $display("FAIL b2b_second got %h lat=%0d want 1 lat=67", res, lat); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
    bus.is_signed = 1'b0; bus.do_rem = 1'b0; bus.is_word = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_word;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
